riscv_core_amo_unit: RTL and testbench
======================================

# riscv_core_amo_unit

Execution-side counterpart to the main decoder's atomic outputs. It consumes the decoded `amo`, `amo_op`, `lr`, `sc` and `size` controls plus operands in the MEM stage. It sequences the read-modify-write or conditional-store transactions on the data-memory port, maintains the single LR/SC reservation, stalls the pipeline while busy, and returns the rd value.

## Interface
- `XLEN`, 64, data/address width.
- `i_clk` input 1 — core clock.
- `i_rst_n` input 1 — reset, asynchronous, active-low.
- `i_amo_unit_start` input 1 — one-cycle request; instruction in MEM is AMO/LR/SC.
- `i_amo_unit_amo` input 1 — AMO read-modify-write.
- `i_amo_unit_lr` input 1 — load-reserved.
- `i_amo_unit_sc` input 1 — store-conditional.
- `i_amo_unit_amo_op` input 4 — AMO operation code:
  - 0000 SWAP, 0001 ADD, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 MAX, 0110 MIN, 0111 MAXU, 1000 MINU.
  - Other codes behave as SWAP.
- `i_amo_unit_size` input 2 — 10 = word, 11 = doubleword; other values are treated as doubleword.
- `i_amo_unit_addr` input XLEN — rs1 address.
- `i_amo_unit_rs2` input XLEN — rs2 operand.
- `i_amo_unit_resv_clear` input 1 — trap/xRET; invalidates the reservation.
- `i_amo_unit_snoop_valid` input 1 — a plain store is retiring this cycle.
- `i_amo_unit_snoop_addr` input XLEN — address of that store.
- `o_amo_unit_busy` output 1 — pipeline stall.
- `o_amo_unit_done` output 1 — one-cycle completion pulse.
- `o_amo_unit_result` output XLEN — rd value, valid with done.
- `o_amo_unit_misaligned` output 1 — with done; access fault, no memory access made.
- `o_mem_valid` output 1 — memory request.
- `o_mem_we` output 1 — 1 = write.
- `o_mem_addr` output XLEN — request address.
- `o_mem_wdata` output XLEN — write data; word data in [31:0], [63:32] = 0.
- `o_mem_size` output 2 — access size, copied from the latched size.
- `i_mem_ready` input 1 — request accepted when `o_mem_valid & i_mem_ready`.
- `i_mem_rvalid` input 1 — read data return, one or more cycles after acceptance.
- `i_mem_rdata` input XLEN — word reads return right-justified in [31:0].

## Operation
- **State machine:** IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE.
- **Accepting a request:**
  - `start` is accepted only in IDLE and is ignored in every other state.
  - On acceptance, addr, rs2, op, size and the type flags are latched.
- **Alignment check:** word requires addr[1:0]=0; doubleword requires addr[2:0]=0.
  - On failure: IDLE→DONE, misaligned=1, result=0, reservation unchanged.
- **LR:** IDLE→RD_REQ→(accept)→RD_WAIT→(rvalid)→DONE.
  - Sets the reservation: valid=1, addr[XLEN-1:3], size.
  - result = loaded value.
- **AMO:** RD_REQ→RD_WAIT→(rvalid)→WR_REQ→(accept)→DONE.
  - Write value = op(loaded, rs2).
  - result = original loaded value.
- **SC:** granule addr[XLEN-1:3] is compared against the reservation.
  - Reservation valid and addr and size match: IDLE→WR_REQ→DONE, writes rs2, result=0.
  - Otherwise: IDLE→DONE, no memory access, result=1.
  - Every SC invalidates the reservation, whatever the outcome.
- **Word arithmetic:**
  - Operands are the low 32 bits; ADD wraps mod 2^32.
  - MIN/MAX compare signed 32-bit; MINU/MAXU compare unsigned 32-bit.
  - result = loaded word sign-extended to 64 bits.
- **Doubleword arithmetic:** full 64-bit; ADD wraps mod 2^64.
- **Reservation invalidation:**
  - `resv_clear` invalidates it.
  - `snoop_valid` with a matching 8-byte granule invalidates it.
  - If an invalidation coincides with an SC compare cycle, the SC fails.
  - If an invalidation coincides with the LR set cycle, the set wins.
- **Write side:** AMO writes never touch the reservation, except through the snoop input.

## Timing
- **Reset:** every output 0, state IDLE, reservation invalid.
  - Reset mid-operation aborts immediately.
  - No further `o_mem_valid`; any outstanding read data is ignored after reset.
- **Busy:** `o_amo_unit_busy` is combinational: (state≠IDLE & state≠DONE) | (IDLE & start).
  - The stall begins in the start cycle and drops in the DONE cycle.
- **Done and result:** done, result and misaligned are registered; they are high for exactly the DONE cycle, then the FSM returns to IDLE.
- **Memory request:**
  - `o_mem_valid` is registered: it is first high the cycle after start (or after rvalid for the AMO write).
  - It holds, with addr, we and wdata stable, until accepted.
- **Minimum latencies** (start at cycle 0, ready=1, rvalid 1 cycle after accept):
  - LR: done at cycle 3.
  - AMO: done at cycle 4.
  - SC success: done at cycle 2.
  - SC fail or misaligned: done at cycle 1.
- **Back-to-back:** a new start is accepted the cycle after DONE.

## Test plan
- **AMOADD.D:**
  - Stimulus: addr 0x1000, mem=0x7FFF_FFFF_FFFF_FFFF, rs2=1.
  - Expect: write 0x8000_0000_0000_0000, result 0x7FFF_FFFF_FFFF_FFFF, done at cycle 4.
- **AMOMIN.W vs AMOMINU.W:**
  - Stimulus: mem word 0xFFFF_FFFF, rs2=5.
  - Expect MIN: write 0xFFFF_FFFF, result 0xFFFF_FFFF_FFFF_FFFF.
  - Expect MINU: write 0x5.
- **LR.D then SC.D:**
  - Stimulus: LR.D 0x2000, then SC.D 0x2000 rs2=0xAB.
  - Expect: one write of 0xAB, result 0.
  - Stimulus: second SC.D 0x2000.
  - Expect: result 1, no `o_mem_valid`.
- **Reservation kill:**
  - Stimulus: LR.W 0x3000, snoop store to 0x3004, then SC.W 0x3000.
  - Expect: result 1, no write.
  - Stimulus: repeat with `resv_clear` instead of the snoop store.
  - Expect: result 1.
- **Misaligned:**
  - Stimulus: AMOSWAP.D at 0x1004.
  - Expect: done at cycle 1, misaligned=1, no memory request, reservation unchanged.
- **Backpressure and reset:**
  - Stimulus: ready held 0 for 5 cycles.
  - Expect: `o_mem_valid`, addr and wdata stable, busy held high.
  - Stimulus: assert `i_rst_n`=0 while in RD_WAIT.
  - Expect: all outputs 0 immediately, a later rvalid is ignored, and the next start works normally.

Source files
------------

// File: rtl/riscv_core_amo_unit.sv
// LR/SC/AMO sequencer for the MEM stage; owns the single reservation. Latency: SC-fail/misaligned 1, SC 2, LR 3, AMO 4 cycles min.
// Backpressure: o_mem_valid/addr/we/wdata held until i_mem_ready; pipeline stalled via combinational o_amo_unit_busy.
module riscv_core_amo_unit #(
    parameter int XLEN = 64
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_amo_unit_start,
    input  logic            i_amo_unit_amo,
    input  logic            i_amo_unit_lr,
    input  logic            i_amo_unit_sc,
    input  logic [3:0]      i_amo_unit_amo_op,
    input  logic [1:0]      i_amo_unit_size,
    input  logic [XLEN-1:0] i_amo_unit_addr,
    input  logic [XLEN-1:0] i_amo_unit_rs2,
    input  logic            i_amo_unit_resv_clear,
    input  logic            i_amo_unit_snoop_valid,
    input  logic [XLEN-1:0] i_amo_unit_snoop_addr,
    output logic            o_amo_unit_busy,
    output logic            o_amo_unit_done,
    output logic [XLEN-1:0] o_amo_unit_result,
    output logic            o_amo_unit_misaligned,
    output logic            o_mem_valid,
    output logic            o_mem_we,
    output logic [XLEN-1:0] o_mem_addr,
    output logic [XLEN-1:0] o_mem_wdata,
    output logic [1:0]      o_mem_size,
    input  logic            i_mem_ready,
    input  logic            i_mem_rvalid,
    input  logic [XLEN-1:0] i_mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_WAIT = 3'd2,
        S_WR_REQ  = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next_state;

    logic [XLEN-1:0]   r_addr;
    logic [XLEN-1:0]   r_rs2;
    logic [3:0]        r_op;
    logic [1:0]        r_size;
    logic              r_dw;
    logic              r_is_lr;
    logic              r_is_sc;
    logic [XLEN-1:0]   r_loaded;

    logic              r_mem_valid;
    logic              r_mem_we;
    logic [XLEN-1:0]   r_mem_wdata;
    logic              r_done;
    logic [XLEN-1:0]   r_result;
    logic              r_misal;

    logic              r_resv_vld;
    logic [XLEN-4:0]   r_resv_addr;
    logic              r_resv_dw;

    logic              w_accept;
    logic              w_in_dw;
    logic              w_in_sc;
    logic              w_in_lr;
    logic              w_in_misal;
    logic              w_snoop_hit;
    logic              w_kill;
    logic              w_sc_ok;
    logic [XLEN-1:0]   w_sc_wdata;

    logic [XLEN-1:0]   w_ld_val;
    logic [XLEN-1:0]   w_rs2_s;
    logic [XLEN-1:0]   w_ld_u;
    logic [XLEN-1:0]   w_rs2_u;
    logic              w_lt_s;
    logic              w_lt_u;
    logic [XLEN-1:0]   w_alu;
    logic [XLEN-1:0]   w_amo_wdata;

    logic              w_mem_valid_nxt;
    logic              w_mem_we_nxt;
    logic [XLEN-1:0]   w_mem_wdata_nxt;
    logic              w_done_nxt;
    logic [XLEN-1:0]   w_result_nxt;
    logic              w_misal_nxt;
    logic              w_resv_set;
    logic              w_resv_sc_kill;
    logic              w_load_cap;
    logic              w_unused;

    // Type flags are decoded one-hot upstream; AMO takes priority, and no flag at all runs as an AMO.
    assign w_accept    = (r_state == S_IDLE) & i_amo_unit_start;
    assign w_in_dw     = (i_amo_unit_size != 2'b10);
    assign w_in_sc     = i_amo_unit_sc & ~i_amo_unit_amo;
    assign w_in_lr     = i_amo_unit_lr & ~i_amo_unit_amo & ~i_amo_unit_sc;
    assign w_in_misal  = w_in_dw ? (i_amo_unit_addr[2:0] != 3'b000) : (i_amo_unit_addr[1:0] != 2'b00);

    assign w_snoop_hit = i_amo_unit_snoop_valid & (i_amo_unit_snoop_addr[XLEN-1:3] == r_resv_addr);
    assign w_kill      = i_amo_unit_resv_clear | w_snoop_hit;
    assign w_sc_ok     = r_resv_vld & ~w_kill & (i_amo_unit_addr[XLEN-1:3] == r_resv_addr) & (r_resv_dw == w_in_dw);
    assign w_sc_wdata  = w_in_dw ? i_amo_unit_rs2 : {32'b0, i_amo_unit_rs2[31:0]};
    assign w_unused    = &{1'b0, i_amo_unit_snoop_addr[2:0]};

    assign w_ld_val    = r_dw ? i_mem_rdata : {{32{i_mem_rdata[31]}}, i_mem_rdata[31:0]};
    assign w_rs2_s     = r_dw ? r_rs2 : {{32{r_rs2[31]}}, r_rs2[31:0]};
    assign w_ld_u      = r_dw ? i_mem_rdata : {32'b0, i_mem_rdata[31:0]};
    assign w_rs2_u     = r_dw ? r_rs2 : {32'b0, r_rs2[31:0]};
    assign w_lt_s      = $signed(w_ld_val) < $signed(w_rs2_s);
    assign w_lt_u      = w_ld_u < w_rs2_u;

    always_comb begin
        w_alu = w_rs2_s;
        case (r_op)
            4'b0001: w_alu = w_ld_val + w_rs2_s;
            4'b0010: w_alu = w_ld_val & w_rs2_s;
            4'b0011: w_alu = w_ld_val | w_rs2_s;
            4'b0100: w_alu = w_ld_val ^ w_rs2_s;
            4'b0101: w_alu = w_lt_s ? w_rs2_s : w_ld_val;
            4'b0110: w_alu = w_lt_s ? w_ld_val : w_rs2_s;
            4'b0111: w_alu = w_lt_u ? w_rs2_s : w_ld_val;
            4'b1000: w_alu = w_lt_u ? w_ld_val : w_rs2_s;
            default: w_alu = w_rs2_s;
        endcase
    end

    assign w_amo_wdata = r_dw ? w_alu : {32'b0, w_alu[31:0]};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state    = r_state;
        w_mem_valid_nxt = r_mem_valid;
        w_mem_we_nxt    = r_mem_we;
        w_mem_wdata_nxt = r_mem_wdata;
        w_done_nxt      = 1'b0;
        w_result_nxt    = '0;
        w_misal_nxt     = 1'b0;
        w_resv_set      = 1'b0;
        w_resv_sc_kill  = 1'b0;
        w_load_cap      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_amo_unit_start) begin
                    if (w_in_misal) begin
                        w_next_state = S_DONE;
                        w_done_nxt   = 1'b1;
                        w_misal_nxt  = 1'b1;
                    end else if (w_in_sc) begin
                        w_resv_sc_kill = 1'b1;
                        if (w_sc_ok) begin
                            w_next_state    = S_WR_REQ;
                            w_mem_valid_nxt = 1'b1;
                            w_mem_we_nxt    = 1'b1;
                            w_mem_wdata_nxt = w_sc_wdata;
                        end else begin
                            w_next_state = S_DONE;
                            w_done_nxt   = 1'b1;
                            w_result_nxt = {{(XLEN-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        w_next_state    = S_RD_REQ;
                        w_mem_valid_nxt = 1'b1;
                        w_mem_we_nxt    = 1'b0;
                    end
                end
            end
            S_RD_REQ: begin
                if (i_mem_ready) begin
                    w_mem_valid_nxt = 1'b0;
                    w_next_state    = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (i_mem_rvalid) begin
                    w_load_cap = 1'b1;
                    if (r_is_lr) begin
                        w_next_state = S_DONE;
                        w_done_nxt   = 1'b1;
                        w_result_nxt = w_ld_val;
                        w_resv_set   = 1'b1;
                    end else begin
                        w_next_state    = S_WR_REQ;
                        w_mem_valid_nxt = 1'b1;
                        w_mem_we_nxt    = 1'b1;
                        w_mem_wdata_nxt = w_amo_wdata;
                    end
                end
            end
            S_WR_REQ: begin
                if (i_mem_ready) begin
                    w_mem_valid_nxt = 1'b0;
                    w_mem_we_nxt    = 1'b0;
                    w_next_state    = S_DONE;
                    w_done_nxt      = 1'b1;
                    w_result_nxt    = r_is_sc ? '0 : r_loaded;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr      <= '0;
            r_rs2       <= '0;
            r_op        <= '0;
            r_size      <= '0;
            r_dw        <= 1'b0;
            r_is_lr     <= 1'b0;
            r_is_sc     <= 1'b0;
            r_loaded    <= '0;
            r_mem_valid <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_done      <= 1'b0;
            r_result    <= '0;
            r_misal     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr  <= i_amo_unit_addr;
                r_rs2   <= i_amo_unit_rs2;
                r_op    <= i_amo_unit_amo_op;
                r_size  <= i_amo_unit_size;
                r_dw    <= w_in_dw;
                r_is_lr <= w_in_lr;
                r_is_sc <= w_in_sc;
            end
            if (w_load_cap) begin
                r_loaded <= w_ld_val;
            end
            r_mem_valid <= w_mem_valid_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            r_done      <= w_done_nxt;
            r_result    <= w_result_nxt;
            r_misal     <= w_misal_nxt;
        end
    end

    // An LR fill outranks a same-cycle kill; an SC always consumes the reservation.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_resv_vld  <= 1'b0;
            r_resv_addr <= '0;
            r_resv_dw   <= 1'b0;
        end else if (w_resv_set) begin
            r_resv_vld  <= 1'b1;
            r_resv_addr <= r_addr[XLEN-1:3];
            r_resv_dw   <= r_dw;
        end else if (w_kill | w_resv_sc_kill) begin
            r_resv_vld  <= 1'b0;
        end
    end

    assign o_amo_unit_busy       = ((r_state != S_IDLE) & (r_state != S_DONE)) |
                                   ((r_state == S_IDLE) & i_amo_unit_start);
    assign o_amo_unit_done       = r_done;
    assign o_amo_unit_result     = r_result;
    assign o_amo_unit_misaligned = r_misal;
    assign o_mem_valid           = r_mem_valid;
    assign o_mem_we              = r_mem_we;
    assign o_mem_addr            = r_addr;
    assign o_mem_wdata           = r_mem_wdata;
    assign o_mem_size            = r_size;

endmodule

// File: tb/tb_riscv_core_amo_unit.sv
// Directed bench for riscv_core_amo_unit with a one-cycle-latency memory responder.
// Outputs are sampled on the falling clock edge.
module tb_riscv_core_amo_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, amo = 1'b0, lr = 1'b0, sc = 1'b0;
    logic [3:0]  op = '0;
    logic [1:0]  size = '0;
    logic [63:0] addr = '0, rs2 = '0;
    logic        resv_clear = 1'b0, snoop_valid = 1'b0;
    logic [63:0] snoop_addr = '0;
    logic        mem_ready = 1'b1;
    logic        auto_en = 1'b1, auto_rv = 1'b0, man_rv = 1'b0;
    logic [63:0] mem_rdata = '0;

    logic        busy, done, misal, mem_valid, mem_we;
    logic [63:0] result, mem_addr, mem_wdata;
    logic [1:0]  mem_size;

    int          total = 0, bad = 0;
    int          rd_cnt = 0, wr_cnt = 0, vld_cyc = 0;
    int          base_rd, base_wr, base_vld;
    logic [63:0] wr_dat = '0, wr_adr = '0;
    int          cyc;
    logic        bs, bd;

    always #5 clk = ~clk;

    riscv_core_amo_unit #(.XLEN(64)) dut (
        .i_clk                  (clk),
        .i_rst_n                (rst_n),
        .i_amo_unit_start       (start),
        .i_amo_unit_amo         (amo),
        .i_amo_unit_lr          (lr),
        .i_amo_unit_sc          (sc),
        .i_amo_unit_amo_op      (op),
        .i_amo_unit_size        (size),
        .i_amo_unit_addr        (addr),
        .i_amo_unit_rs2         (rs2),
        .i_amo_unit_resv_clear  (resv_clear),
        .i_amo_unit_snoop_valid (snoop_valid),
        .i_amo_unit_snoop_addr  (snoop_addr),
        .o_amo_unit_busy        (busy),
        .o_amo_unit_done        (done),
        .o_amo_unit_result      (result),
        .o_amo_unit_misaligned  (misal),
        .o_mem_valid            (mem_valid),
        .o_mem_we               (mem_we),
        .o_mem_addr             (mem_addr),
        .o_mem_wdata            (mem_wdata),
        .o_mem_size             (mem_size),
        .i_mem_ready            (mem_ready),
        .i_mem_rvalid           (auto_rv | man_rv),
        .i_mem_rdata            (mem_rdata)
    );

    // Memory responder: returns read data the cycle after acceptance and logs writes.
    always @(posedge clk) begin
        auto_rv <= 1'b0;
        if (mem_valid && mem_ready) begin
            if (mem_we) begin
                wr_cnt <= wr_cnt + 1;
                wr_dat <= mem_wdata;
                wr_adr <= mem_addr;
            end else begin
                rd_cnt  <= rd_cnt + 1;
                auto_rv <= auto_en;
            end
        end
        if (mem_valid) vld_cyc <= vld_cyc + 1;
    end

    task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic snap();
        base_rd  = rd_cnt;
        base_wr  = wr_cnt;
        base_vld = vld_cyc;
    endtask

    task automatic do_op(input logic a, input logic l, input logic s, input logic [3:0] o,
                         input logic [1:0] sz, input logic [63:0] ad, input logic [63:0] r2,
                         output int c, output logic b_start, output logic b_done);
        @(negedge clk);
        start = 1'b1; amo = a; lr = l; sc = s; op = o; size = sz; addr = ad; rs2 = r2;
        #1 b_start = busy;
        @(negedge clk);
        start = 1'b0; amo = 1'b0; lr = 1'b0; sc = 1'b0;
        c = 1;
        while (!done && c < 20) begin
            @(negedge clk);
            c++;
        end
        if (!done) c = -1;
        b_done = busy;
    endtask

    task automatic pulse_snoop(input logic [63:0] a);
        @(negedge clk);
        snoop_valid = 1'b1; snoop_addr = a;
        @(negedge clk);
        snoop_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_valid", mem_valid, 1'b0);
        chk64("rst_result", result, 64'h0);
        chk64("rst_addr", mem_addr, 64'h0);
        rst_n = 1'b1;

        // AMOADD.D overflow
        mem_rdata = 64'h7FFF_FFFF_FFFF_FFFF; snap();
        do_op(1, 0, 0, 4'b0001, 2'b11, 64'h1000, 64'h1, cyc, bs, bd);
        chk1("addd_busy_start", bs, 1'b1);
        chk1("addd_busy_done", bd, 1'b0);
        chk64("addd_cycles", 64'(cyc), 64'd4);
        chk64("addd_result", result, 64'h7FFF_FFFF_FFFF_FFFF);
        chk64("addd_wdata", wr_dat, 64'h8000_0000_0000_0000);
        chk64("addd_waddr", wr_adr, 64'h1000);
        chk64("addd_nwr", 64'(wr_cnt - base_wr), 64'd1);
        chk64("addd_nrd", 64'(rd_cnt - base_rd), 64'd1);

        // AMOMIN.W issued back-to-back
        mem_rdata = 64'h0000_0000_FFFF_FFFF;
        do_op(1, 0, 0, 4'b0110, 2'b10, 64'h1100, 64'h5, cyc, bs, bd);
        chk1("minw_busy_start", bs, 1'b1);
        chk64("minw_cycles", 64'(cyc), 64'd4);
        chk64("minw_wdata", wr_dat, 64'h0000_0000_FFFF_FFFF);
        chk64("minw_result", result, 64'hFFFF_FFFF_FFFF_FFFF);

        do_op(1, 0, 0, 4'b1000, 2'b10, 64'h1100, 64'h5, cyc, bs, bd);
        chk64("minuw_wdata", wr_dat, 64'h5);
        chk64("minuw_result", result, 64'hFFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        chk1("done_one_cycle", done, 1'b0);
        chk64("result_cleared", result, 64'h0);

        // Word add wraps mod 2^32
        do_op(1, 0, 0, 4'b0001, 2'b10, 64'h1104, 64'h2, cyc, bs, bd);
        chk64("addw_wdata", wr_dat, 64'h1);
        // Signed 64-bit max with most-negative operand
        mem_rdata = 64'h8000_0000_0000_0000;
        do_op(1, 0, 0, 4'b0101, 2'b11, 64'h1108, 64'h1, cyc, bs, bd);
        chk64("maxd_wdata", wr_dat, 64'h1);
        chk64("maxd_result", result, 64'h8000_0000_0000_0000);
        // Undefined op code behaves as SWAP
        mem_rdata = 64'h55;
        do_op(1, 0, 0, 4'b1111, 2'b11, 64'h1110, 64'h66, cyc, bs, bd);
        chk64("badop_wdata", wr_dat, 64'h66);

        // LR.D / SC.D / second SC.D
        mem_rdata = 64'h1234_5678_9ABC_DEF0; snap();
        do_op(0, 1, 0, 4'b0000, 2'b11, 64'h2000, 64'h0, cyc, bs, bd);
        chk64("lrd_cycles", 64'(cyc), 64'd3);
        chk64("lrd_result", result, 64'h1234_5678_9ABC_DEF0);
        chk64("lrd_nwr", 64'(wr_cnt - base_wr), 64'd0);
        snap();
        do_op(0, 0, 1, 4'b0000, 2'b11, 64'h2000, 64'hAB, cyc, bs, bd);
        chk64("scd_cycles", 64'(cyc), 64'd2);
        chk64("scd_result", result, 64'h0);
        chk64("scd_wdata", wr_dat, 64'hAB);
        chk64("scd_nwr", 64'(wr_cnt - base_wr), 64'd1);
        chk64("scd_nrd", 64'(rd_cnt - base_rd), 64'd0);
        snap();
        do_op(0, 0, 1, 4'b0000, 2'b11, 64'h2000, 64'hCD, cyc, bs, bd);
        chk64("sc2_cycles", 64'(cyc), 64'd1);
        chk64("sc2_result", result, 64'h1);
        chk64("sc2_nvalid", 64'(vld_cyc - base_vld), 64'd0);

        // Reservation killed by snoop in the same granule
        mem_rdata = 64'h0000_0000_8000_0001;
        do_op(0, 1, 0, 4'b0000, 2'b10, 64'h3000, 64'h0, cyc, bs, bd);
        chk64("lrw_result", result, 64'hFFFF_FFFF_8000_0001);
        pulse_snoop(64'h3004);
        snap();
        do_op(0, 0, 1, 4'b0000, 2'b10, 64'h3000, 64'h7, cyc, bs, bd);
        chk64("snoopkill_result", result, 64'h1);
        chk64("snoopkill_nvalid", 64'(vld_cyc - base_vld), 64'd0);

        // Reservation killed by resv_clear
        do_op(0, 1, 0, 4'b0000, 2'b10, 64'h3000, 64'h0, cyc, bs, bd);
        @(negedge clk); resv_clear = 1'b1;
        @(negedge clk); resv_clear = 1'b0;
        do_op(0, 0, 1, 4'b0000, 2'b10, 64'h3000, 64'h7, cyc, bs, bd);
        chk64("clrkill_result", result, 64'h1);

        // Snoop to the neighbouring granule leaves the reservation intact
        do_op(0, 1, 0, 4'b0000, 2'b10, 64'h3000, 64'h0, cyc, bs, bd);
        pulse_snoop(64'h3008);
        do_op(0, 0, 1, 4'b0000, 2'b10, 64'h3000, 64'h1_2345_6789, cyc, bs, bd);
        chk64("nbr_result", result, 64'h0);
        chk64("nbr_wdata", wr_dat, 64'h0000_0000_2345_6789);

        // Size mismatch between LR.W and SC.D fails
        do_op(0, 1, 0, 4'b0000, 2'b10, 64'h3000, 64'h0, cyc, bs, bd);
        do_op(0, 0, 1, 4'b0000, 2'b11, 64'h3000, 64'h9, cyc, bs, bd);
        chk64("sizemis_result", result, 64'h1);

        // Misaligned AMO leaves reservation in place
        do_op(0, 1, 0, 4'b0000, 2'b11, 64'h4000, 64'h0, cyc, bs, bd);
        snap();
        do_op(1, 0, 0, 4'b0000, 2'b11, 64'h1004, 64'h1, cyc, bs, bd);
        chk64("misd_cycles", 64'(cyc), 64'd1);
        chk1("misd_flag", misal, 1'b1);
        chk64("misd_result", result, 64'h0);
        chk64("misd_nvalid", 64'(vld_cyc - base_vld), 64'd0);
        do_op(1, 0, 0, 4'b0001, 2'b10, 64'h1002, 64'h1, cyc, bs, bd);
        chk1("misw_flag", misal, 1'b1);
        do_op(0, 0, 1, 4'b0000, 2'b11, 64'h4000, 64'h77, cyc, bs, bd);
        chk64("mis_resv_kept", result, 64'h0);
        chk1("sc_misal_low", misal, 1'b0);

        // Backpressure on read and write requests
        mem_ready = 1'b0; mem_rdata = 64'h0F0F; snap();
        @(negedge clk);
        start = 1'b1; amo = 1'b1; op = 4'b0100; size = 2'b11; addr = 64'h5000; rs2 = 64'hFF;
        @(negedge clk);
        start = 1'b0; amo = 1'b0; addr = 64'h0; rs2 = 64'h0;
        for (int k = 0; k < 5; k++) begin
            chk1("bp_rd_valid", mem_valid, 1'b1);
            chk1("bp_rd_we", mem_we, 1'b0);
            chk64("bp_rd_addr", mem_addr, 64'h5000);
            chk1("bp_rd_busy", busy, 1'b1);
            if (k < 4) @(negedge clk);
        end
        chk64("bp_size", {62'b0, mem_size}, 64'd3);
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        for (int k = 0; k < 10 && !(mem_valid && mem_we); k++) @(negedge clk);
        chk1("bp_wr_seen", mem_valid & mem_we, 1'b1);
        for (int k = 0; k < 3; k++) begin
            chk1("bp_wr_valid", mem_valid, 1'b1);
            chk64("bp_wr_wdata", mem_wdata, 64'h0FF0);
            chk64("bp_wr_addr", mem_addr, 64'h5000);
            chk1("bp_wr_busy", busy, 1'b1);
            @(negedge clk);
        end
        mem_ready = 1'b1;
        for (int k = 0; k < 10 && !done; k++) @(negedge clk);
        chk1("bp_done", done, 1'b1);
        chk64("bp_result", result, 64'h0F0F);
        chk64("bp_nwr", 64'(wr_cnt - base_wr), 64'd1);
        chk64("bp_nrd", 64'(rd_cnt - base_rd), 64'd1);

        // Reset while waiting for read data
        auto_en = 1'b0;
        @(negedge clk);
        start = 1'b1; lr = 1'b1; size = 2'b11; addr = 64'h6000;
        @(negedge clk);
        start = 1'b0; lr = 1'b0;
        chk1("rw_req_valid", mem_valid, 1'b1);
        @(negedge clk);
        chk1("rw_wait_busy", busy, 1'b1);
        chk1("rw_wait_valid", mem_valid, 1'b0);
        rst_n = 1'b0;
        #1;
        chk1("rw_rst_busy", busy, 1'b0);
        chk1("rw_rst_valid", mem_valid, 1'b0);
        chk1("rw_rst_done", done, 1'b0);
        chk64("rw_rst_addr", mem_addr, 64'h0);
        chk64("rw_rst_size", {62'b0, mem_size}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1; man_rv = 1'b1; mem_rdata = 64'hDEAD;
        @(negedge clk);
        man_rv = 1'b0;
        chk1("rw_stray_done", done, 1'b0);
        chk1("rw_stray_valid", mem_valid, 1'b0);
        chk1("rw_stray_busy", busy, 1'b0);
        auto_en = 1'b1;
        mem_rdata = 64'h7FFF_FFFF_FFFF_FFFF;
        do_op(1, 0, 0, 4'b0001, 2'b11, 64'h1000, 64'h1, cyc, bs, bd);
        chk64("post_rst_cycles", 64'(cyc), 64'd4);
        chk64("post_rst_result", result, 64'h7FFF_FFFF_FFFF_FFFF);
        chk64("post_rst_wdata", wr_dat, 64'h8000_0000_0000_0000);
        // Reset also dropped the old reservation
        do_op(0, 0, 1, 4'b0000, 2'b11, 64'h2000, 64'h1, cyc, bs, bd);
        chk64("post_rst_sc", result, 64'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
